// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - RV64 load/store unit over a 64-bit doubleword memory
//
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   req_valid/req_ready          request handshake from execute stage
//   req_we, req_funct3           store flag and RV funct3 (size / signedness)
//   req_addr, req_wdata          byte address, right-aligned store data
//   resp_valid/resp_err          one-cycle completion pulse, error flag
//   resp_rdata                   extended load data (0 for stores and errors)
//   mem_read/mem_write           registered memory strobes
//   mem_addr, mem_wdata          doubleword index, full doubleword to write
//   mem_rdata                    read data, valid the cycle after mem_read
module load_store_unit #(
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [63:0]       req_wdata,
  output logic              resp_valid,
  output logic              resp_err,
  output logic [63:0]       resp_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-4:0] mem_addr,
  output logic [63:0]       mem_wdata,
  input  logic [63:0]       mem_rdata
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] RD_ISSUE = 3'd1;
  localparam logic [2:0] RD_WAIT  = 3'd2;
  localparam logic [2:0] WR_ISSUE = 3'd3;
  localparam logic [2:0] RESP     = 3'd4;

  logic [2:0]        state_q, state_d;
  logic              we_q, we_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [2:0]        off_q, off_d;
  logic [63:0]       wdata_q, wdata_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic [ADDR_W-4:0] mem_addr_q, mem_addr_d;
  logic [63:0]       mem_wdata_q, mem_wdata_d;
  logic              resp_valid_q, resp_valid_d;
  logic              resp_err_q, resp_err_d;
  logic [63:0]       resp_rdata_q, resp_rdata_d;

  logic        req_bad;
  logic [5:0]  sh;
  logic [63:0] shifted, load_ext, lane_mask, bit_mask, merged;

  // The memory index is the only part of the upper address needed later,
  // so only the byte offset is kept beside it.
  always_comb begin
    logic [2:0] off;
    logic       misal;
    logic       illegal;
    off     = req_addr[2:0];
    misal   = ((req_funct3[1:0] == 2'b01) && off[0])
            || ((req_funct3[1:0] == 2'b10) && (off[1:0] != 2'b00))
            || ((req_funct3[1:0] == 2'b11) && (off != 3'b000));
    illegal = req_we ? req_funct3[2] : (req_funct3 == 3'b111);
    req_bad = misal || illegal;
  end

  // Load extraction and store merge both work on the doubleword read in RD_WAIT.
  always_comb begin
    sh      = {off_q, 3'b000};
    shifted = mem_rdata >> sh;
    case (funct3_q)
      3'b000:  load_ext = {{56{shifted[7]}},  shifted[7:0]};
      3'b001:  load_ext = {{48{shifted[15]}}, shifted[15:0]};
      3'b010:  load_ext = {{32{shifted[31]}}, shifted[31:0]};
      3'b011:  load_ext = shifted;
      3'b100:  load_ext = {56'd0, shifted[7:0]};
      3'b101:  load_ext = {48'd0, shifted[15:0]};
      3'b110:  load_ext = {32'd0, shifted[31:0]};
      default: load_ext = 64'd0;
    endcase
    case (funct3_q[1:0])
      2'b00:   lane_mask = 64'h0000_0000_0000_00FF;
      2'b01:   lane_mask = 64'h0000_0000_0000_FFFF;
      2'b10:   lane_mask = 64'h0000_0000_FFFF_FFFF;
      default: lane_mask = 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
    bit_mask = lane_mask << sh;
    merged   = (mem_rdata & ~bit_mask) | ((wdata_q << sh) & bit_mask);
  end

  // Strobes and response fields are single-cycle pulses; address and write
  // data hold so mem_addr stays stable from issue through WR_ISSUE.
  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    funct3_d     = funct3_q;
    off_d        = off_q;
    wdata_d      = wdata_q;
    mem_read_d   = 1'b0;
    mem_write_d  = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    resp_rdata_d = 64'd0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d     = req_we;
          funct3_d = req_funct3;
          off_d    = req_addr[2:0];
          wdata_d  = req_wdata;
          if (req_bad) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end else if (req_we && (req_funct3[1:0] == 2'b11)) begin
            state_d     = WR_ISSUE;
            mem_write_d = 1'b1;
            mem_addr_d  = req_addr[ADDR_W-1:3];
            mem_wdata_d = req_wdata;
          end else begin
            state_d    = RD_ISSUE;
            mem_read_d = 1'b1;
            mem_addr_d = req_addr[ADDR_W-1:3];
          end
        end
      end
      RD_ISSUE: state_d = RD_WAIT;
      RD_WAIT: begin
        if (we_q) begin
          state_d     = WR_ISSUE;
          mem_write_d = 1'b1;
          mem_wdata_d = merged;
        end else begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
          resp_rdata_d = load_ext;
        end
      end
      WR_ISSUE: begin
        state_d      = RESP;
        resp_valid_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      we_q         <= 1'b0;
      funct3_q     <= 3'd0;
      off_q        <= 3'd0;
      wdata_q      <= 64'd0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= 64'd0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 64'd0;
    end else begin
      state_q      <= state_d;
      we_q         <= we_d;
      funct3_q     <= funct3_d;
      off_q        <= off_d;
      wdata_q      <= wdata_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign mem_read   = mem_read_q;
  assign mem_write  = mem_write_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;

endmodule
